// File: rtl/flappy_pkg.sv
// Shared types and matrix geometry for the flappy pipe datapath.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } game_state_t;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 8;
    localparam int SCORE_W     = 8;

endpackage

// File: rtl/step_timer.sv
// Enable-gated modulo-STEP_CYCLES counter; strobes step_o on its last count.
module step_timer #(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    input  logic freeze_i,
    output logic step_o
);

    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;
    logic          at_end_s;

    assign at_end_s = (tick_q == TW'(STEP_CYCLES - 1));
    assign step_o   = at_end_s && enable_i && !freeze_i;

    // Next tick: hold while frozen or paused, wrap on the step cycle.
    always_comb begin
        tick_d = tick_q;
        if (freeze_i || !enable_i) begin
            tick_d = tick_q;
        end else if (at_end_s) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + TW'(1);
        end
    end

    // Tick register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls sampled pipe patterns right-to-left, detects bird collision and
// counts pipes that have passed the bird column.
module pipe_scroller
    import flappy_pkg::*;
#(
    parameter int COLS        = MATRIX_COLS,
    parameter int ROWS        = MATRIX_ROWS,
    parameter int STEP_CYCLES = 4,
    parameter int GAP_COLS    = 3,
    parameter int BIRD_COL    = 1
) (
    input  logic                     Clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [ROWS-1:0]          pattern,
    input  logic [$clog2(ROWS)-1:0]  bird_row,
    output logic                     pattern_take,
    output logic                     step,
    output logic [COLS*ROWS-1:0]     cols,
    output logic                     collision,
    output logic [SCORE_W-1:0]       score
);

    localparam int SPW = (GAP_COLS > 0) ? $clog2(GAP_COLS + 1) : 1;

    game_state_t           state_q;
    game_state_t           state_d;
    logic [COLS*ROWS-1:0]  cols_q;
    logic [COLS*ROWS-1:0]  cols_d;
    logic [SPW-1:0]        spawn_q;
    logic [SPW-1:0]        spawn_d;
    logic                  coll_q;
    logic                  coll_d;
    logic [SCORE_W-1:0]    score_q;
    logic [SCORE_W-1:0]    score_d;

    logic                  timer_step_s;
    logic                  hit_s;
    logic                  step_s;
    logic                  take_s;
    logic [ROWS-1:0]       bird_col_s;
    logic [ROWS-1:0]       entry_s;

    step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .clk_i    (Clock),
        .reset_i  (reset),
        .enable_i (enable),
        .freeze_i (state_q != RUN),
        .step_o   (timer_step_s)
    );

    assign bird_col_s = cols_q[BIRD_COL*ROWS +: ROWS];
    assign hit_s      = (state_q == RUN) && bird_col_s[bird_row];
    // A step that coincides with a hit never happens: the game ends instead.
    assign step_s     = timer_step_s && !hit_s;
    assign take_s     = step_s && (spawn_q == '0);
    assign entry_s    = take_s ? pattern : '0;

    assign step         = step_s;
    assign pattern_take = take_s;
    assign cols         = cols_q;
    assign collision    = coll_q;
    assign score        = score_q;

    // Game FSM and step datapath next-state.
    always_comb begin
        state_d = state_q;
        cols_d  = cols_q;
        spawn_d = spawn_q;
        coll_d  = coll_q;
        score_d = score_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (hit_s) begin
                    state_d = DEAD;
                    coll_d  = 1'b1;
                end else if (step_s) begin
                    cols_d = {entry_s, cols_q[COLS*ROWS-1:ROWS]};
                    if (take_s) begin
                        spawn_d = SPW'(GAP_COLS);
                    end else begin
                        spawn_d = spawn_q - SPW'(1);
                    end
                    if ((bird_col_s != '0) && (score_q != {SCORE_W{1'b1}})) begin
                        score_d = score_q + SCORE_W'(1);
                    end else begin
                        score_d = score_q;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DEAD: begin
                state_d = DEAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q <= IDLE;
            cols_q  <= '0;
            spawn_q <= '0;
            coll_q  <= 1'b0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            cols_q  <= cols_d;
            spawn_q <= spawn_d;
            coll_q  <= coll_d;
            score_q <= score_d;
        end
    end

endmodule
